// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: issues one variable-latency imem request per PC value and
// writes the returned word (or a bubble) into the IF/ID pipeline register.
// Ports: clk_i/rst_i, start_i run enable, pc_i from the PC register, stall_i/flush_i from ID,
//        pc_stall_o to the PC, imem_req_o/imem_addr_o/imem_ack_i/imem_data_i memory handshake,
//        ifid_valid_o/ifid_pc_o/ifid_pc4_o/ifid_instr_o IF/ID register outputs.
module if_fetch_unit #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter logic [31:0] PC_INC    = 32'd4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] pc_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic        pc_stall_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic        ifid_valid_o,
    output logic [31:0] ifid_pc_o,
    output logic [31:0] ifid_pc4_o,
    output logic [31:0] ifid_instr_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD,
        S_DRAIN
    } state_t;

    // What the IF/ID register does on the next edge.
    typedef enum logic [1:0] {
        OP_HOLD,
        OP_BUBBLE,
        OP_LOAD_MEM,
        OP_LOAD_SKID
    } ifid_op_t;

    state_t      state_q, state_d;
    ifid_op_t    ifid_op;
    logic [31:0] addr_q, addr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_instr_q, skid_instr_d;

    logic        ifid_valid_d;
    logic [31:0] ifid_pc_d, ifid_pc4_d, ifid_instr_d;

    // Destination after a word is finished: keep fetching only while the CPU runs.
    state_t      resume_state;
    assign resume_state = start_i ? S_FETCH : S_IDLE;

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        ifid_op      = OP_HOLD;
        imem_req_o   = 1'b0;
        imem_addr_o  = addr_q;
        pc_stall_o   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (flush_i) begin
                    ifid_op = OP_BUBBLE;
                end
                if (start_i) begin
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                imem_req_o  = 1'b1;
                imem_addr_o = pc_i;
                addr_d      = pc_i;
                if (imem_ack_i) begin
                    // Word returned this cycle: PC is free to advance.
                    pc_stall_o = 1'b0;
                    if (flush_i) begin
                        ifid_op = OP_BUBBLE;
                        state_d = resume_state;
                    end else if (stall_i) begin
                        // ID cannot take it yet; park the word until the stall clears.
                        skid_pc_d    = pc_i;
                        skid_instr_d = imem_data_i;
                        state_d      = S_HOLD;
                    end else begin
                        ifid_op = OP_LOAD_MEM;
                        state_d = resume_state;
                    end
                end else if (flush_i) begin
                    // Let the PC take the branch target, but the memory still owes
                    // us an ack for the old address: wait it out in DRAIN.
                    pc_stall_o = 1'b0;
                    ifid_op    = OP_BUBBLE;
                    state_d    = S_DRAIN;
                end else begin
                    pc_stall_o = 1'b1;
                    ifid_op    = stall_i ? OP_HOLD : OP_BUBBLE;
                    if (!start_i) begin
                        state_d = S_DRAIN;
                    end
                end
            end

            S_HOLD: begin
                if (flush_i) begin
                    pc_stall_o = 1'b0;
                    ifid_op    = OP_BUBBLE;
                    state_d    = resume_state;
                end else if (!stall_i) begin
                    pc_stall_o = 1'b1;
                    ifid_op    = OP_LOAD_SKID;
                    state_d    = resume_state;
                end else begin
                    pc_stall_o = 1'b1;
                end
            end

            S_DRAIN: begin
                // Old request stays on the bus with its original address until acked.
                imem_req_o  = 1'b1;
                imem_addr_o = addr_q;
                pc_stall_o  = 1'b1;
                ifid_op     = (stall_i && !flush_i) ? OP_HOLD : OP_BUBBLE;
                if (imem_ack_i) begin
                    state_d = resume_state;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // IF/ID register input mux
    // ------------------------------------------------------------------
    always_comb begin
        ifid_valid_d = ifid_valid_o;
        ifid_pc_d    = ifid_pc_o;
        ifid_pc4_d   = ifid_pc4_o;
        ifid_instr_d = ifid_instr_o;
        case (ifid_op)
            OP_BUBBLE: begin
                ifid_valid_d = 1'b0;
                ifid_pc_d    = 32'h0;
                ifid_pc4_d   = 32'h0;
                ifid_instr_d = NOP_INSTR;
            end
            OP_LOAD_MEM: begin
                ifid_valid_d = 1'b1;
                ifid_pc_d    = pc_i;
                ifid_pc4_d   = pc_i + PC_INC;
                ifid_instr_d = imem_data_i;
            end
            OP_LOAD_SKID: begin
                ifid_valid_d = 1'b1;
                ifid_pc_d    = skid_pc_q;
                ifid_pc4_d   = skid_pc_q + PC_INC;
                ifid_instr_d = skid_instr_q;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, address and IF/ID registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            addr_q       <= 32'h0;
            skid_pc_q    <= 32'h0;
            skid_instr_q <= NOP_INSTR;
            ifid_valid_o <= 1'b0;
            ifid_pc_o    <= 32'h0;
            ifid_pc4_o   <= 32'h0;
            ifid_instr_o <= NOP_INSTR;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            ifid_valid_o <= ifid_valid_d;
            ifid_pc_o    <= ifid_pc_d;
            ifid_pc4_o   <= ifid_pc4_d;
            ifid_instr_o <= ifid_instr_d;
        end
    end

endmodule
